accum_op_sequencer: RTL
=======================

Name: accum_op_sequencer

Overview:
Initiator-side controller that drives the accum5 operand/opcode interface (a, b, m, cin) and captures its response (r, of). A host loads a short program of ALU operations, pulses start, and the block issues one operation per clock. Each result is stored per-index for host readback, and overflows are counted. It sits between the host/bus register block and accum5, replacing hand-driven stimulus with a programmable issue engine.

Parameters:
DEPTH, 16, program/result entries (power of two, 2..64)
AW, 4, address width, log2(DEPTH)
ACC_LAT, 1, cycles from operand issue to valid r/of at accum5 output (1..4)

Ports:
Clk  in  1  rising-edge clock
nReset  in  1  synchronous active-low reset
prog_we  in  1  program write strobe (accepted only in IDLE)
prog_addr  in  AW  program write index
prog_data  in  13  {m[3:0], a[3:0], b[3:0], cin}
start  in  1  one-cycle run request (accepted only in IDLE)
len  in  AW+1  number of ops to run, sampled with start
a  out  4  operand A to accum5
b  out  4  operand B to accum5
m  out  4  opcode to accum5
cin  out  1  carry-in to accum5
issue_vld  out  1  high on cycles where a/b/m/cin carry a real op
r  in  4  accum5 result
of  in  1  accum5 overflow/carry flag
res_addr  in  AW  result read index
res_data  out  5  {of, r} at res_addr, registered (1-cycle read latency)
busy  out  1  high in ISSUE and DRAIN
done  out  1  one-cycle pulse on run completion
of_count  out  AW+1  count of captured results with of=1 in last run

Behaviour:
- Reset (nReset=0 at a Clk edge): state=IDLE; a=b=m=0, cin=0, issue_vld=0, busy=0, done=0, of_count=0, res_data=0, pipeline valids cleared. Program and result memories are not cleared.
- Reset mid-run: abandons the run at that edge; no further captures; done is not pulsed.
- IDLE: prog_we writes prog_data to prog[prog_addr]. On start, latch n = min(len, DEPTH) and clear of_count. If n=0, go to DONE; otherwise go to ISSUE with idx=0.
- ISSUE: each cycle drives prog[idx] onto the registered outputs with issue_vld=1, then idx++. After driving idx=n-1, go to DRAIN.
- DRAIN: hold outputs at 0 with issue_vld=0. When the last capture has completed, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Capture pipeline: an ACC_LAT-deep shift register of {vld, idx} tracks issued ops. When the tail is valid, write {of, r} to res[idx]; if of=1, increment of_count (saturating at 2^(AW+1)-1).
- Latency: op k is issued at cycle k after entering ISSUE and its result is written at cycle k+ACC_LAT. A run of n ops drives done at cycle n+ACC_LAT+1 after start is sampled.
- start or prog_we while busy or in DONE: ignored, with no side effects.
- Simultaneous start and prog_we in IDLE: the write occurs, and the run reads the post-write contents.
- len > DEPTH: clamped to DEPTH. idx never wraps within a run.
- res_addr read is valid in any state. Reads of entries not yet written in the current run return stale data.
- Outputs a/b/m/cin/issue_vld are registered, with no combinational path from inputs.

Decomposition:
- accum_pkg: opcode constants OP_ADD=4'b0000, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_NOT, OP_INC, OP_DEC, OP_SHL0, OP_SHL1, OP_SHR0, OP_SHR1, OP_SLA, OP_SRA, OP_ROL, OP_ROR=4'b1111; instruction width 13 and field offsets; state encoding IDLE/ISSUE/DRAIN/DONE.
- Sub-module: accum_seq_ram (1 write port, 1 read port, parameterised width/depth). Instantiate it twice: program memory (13 bits) and result memory (5 bits).

Test Plan:
- Reset values: hold nReset=0 for 2 edges mid-idle. Required: all outputs 0, busy=0, of_count=0.
- Three-op run against the accum5 model: load {ADD,1111,0001,0}, {SUB,1111,1001,0}, {AND,1010,0101,0}; start with len=3. Required: issue_vld high 3 cycles with exact operands in order; res[0]={1,0000}, res[1]={0,0110}, res[2]={0,0000}; of_count=1; done at cycle 5 (ACC_LAT=1).
- len=0: start with len=0. Required: issue_vld never asserts, done pulses the cycle after DONE entry, results unchanged.
- len=20 with DEPTH=16, all entries {INC,0111,0000,0}. Required: exactly 16 issues; res[15]={0,1000}; busy drops before done.
- Ignored requests: assert start and prog_we to entry 0 during ISSUE. Required: run unaffected, prog[0] unchanged (verify via a later run).
- Reset mid-run: assert nReset=0 at the third issue cycle of an 8-op run. Required: next cycle is IDLE, issue_vld=0, done never pulses, res[3..7] untouched.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared constants for the accum5 operation sequencer: opcodes, the
// instruction word layout, result width and the FSM state encoding.
package accum_pkg;

    // Instruction word is {m[3:0], a[3:0], b[3:0], cin}.
    localparam int INSTR_W = 13;
    localparam int CIN_LSB = 0;
    localparam int B_LSB   = 1;
    localparam int A_LSB   = 5;
    localparam int M_LSB   = 9;

    // Captured result word is {of, r[3:0]}.
    localparam int RES_W = 5;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_CMP  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_INC  = 4'b0110;
    localparam logic [3:0] OP_DEC  = 4'b0111;
    localparam logic [3:0] OP_SHL0 = 4'b1000;
    localparam logic [3:0] OP_SHL1 = 4'b1001;
    localparam logic [3:0] OP_SHR0 = 4'b1010;
    localparam logic [3:0] OP_SHR1 = 4'b1011;
    localparam logic [3:0] OP_SLA  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_ROL  = 4'b1110;
    localparam logic [3:0] OP_ROR  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/accum_op_sequencer_if.sv
// Operand/opcode and response signals between the sequencer (master)
// and the accum5 datapath (slave).
interface accum_op_sequencer_if;

    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] m;
    logic       cin;
    logic       issue_vld;
    logic [3:0] r;
    logic       of;

    modport master (output a, b, m, cin, issue_vld, input r, of);
    modport slave  (input a, b, m, cin, issue_vld, output r, of);

endinterface

// File: rtl/accum_seq_ram.sv
// Simple storage array: one synchronous write port, one asynchronous read
// port. Used for both the program store and the result store.
module accum_seq_ram #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    // NOTE: storage has no reset; contents survive nReset and are stale until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/accum_op_sequencer.sv
// Programmable issue engine for accum5: runs a loaded list of operations,
// one per clock, and stores each {of, r} response by index for readback.
module accum_op_sequencer
    import accum_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int ACC_LAT = 1
) (
    input  logic                 Clk,
    input  logic                 nReset,
    input  logic                 prog_we,
    input  logic [AW-1:0]        prog_addr,
    input  logic [INSTR_W-1:0]   prog_data,
    input  logic                 start,
    input  logic [AW:0]          len,
    accum_op_sequencer_if.master acc,
    input  logic [AW-1:0]        res_addr,
    output logic [RES_W-1:0]     res_data,
    output logic                 busy,
    output logic                 done,
    output logic [AW:0]          of_count
);

    localparam logic [AW:0] DEPTH_LEN = (AW + 1)'(DEPTH);

    state_t               state;
    logic [AW-1:0]        idx;
    logic [AW:0]          run_len;
    logic [AW:0]          len_clamped;
    logic                 last_issue;
    logic                 prog_wr;
    logic [INSTR_W-1:0]   prog_word;
    logic [ACC_LAT-1:0]   pipe_vld;
    logic [AW-1:0]        pipe_idx [ACC_LAT];
    logic                 drain_busy;
    logic                 cap_we;
    logic [RES_W-1:0]     res_rdata;

    assign len_clamped = (len > DEPTH_LEN) ? DEPTH_LEN : len;
    assign last_issue  = ({1'b0, idx} == (run_len - 1'b1));
    assign prog_wr     = nReset && prog_we && (state == IDLE);
    // A capture on the reset edge is dropped so an abandoned run writes nothing more.
    assign cap_we      = nReset && pipe_vld[ACC_LAT-1];

    accum_seq_ram #(.WIDTH(INSTR_W), .DEPTH(DEPTH), .AW(AW)) u_prog_ram (
        .clk   (Clk),
        .we    (prog_wr),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (idx),
        .rdata (prog_word)
    );

    accum_seq_ram #(.WIDTH(RES_W), .DEPTH(DEPTH), .AW(AW)) u_res_ram (
        .clk   (Clk),
        .we    (cap_we),
        .waddr (pipe_idx[ACC_LAT-1]),
        .wdata ({acc.of, acc.r}),
        .raddr (res_addr),
        .rdata (res_rdata)
    );

    // Results still in flight ahead of the tail stage keep the engine in DRAIN.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        drain_busy = 1'b0;
        for (int i = 0; i < ACC_LAT - 1; i++) begin
            drain_busy = drain_busy | pipe_vld[i];
        end
    end

    // Shift {vld, idx} of each issued op along until accum5's response is valid.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            pipe_vld <= '0;
            for (int i = 0; i < ACC_LAT; i++) begin
                pipe_idx[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= (state == ISSUE);
            pipe_idx[0] <= idx;
            for (int i = 1; i < ACC_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

    // Run control FSM with registered operand, status and counter outputs.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state         <= IDLE;
            idx           <= '0;
            run_len       <= '0;
            acc.a         <= '0;
            acc.b         <= '0;
            acc.m         <= '0;
            acc.cin       <= 1'b0;
            acc.issue_vld <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            of_count      <= '0;
        end else begin
            // Operands are zero and idle unless ISSUE drives a real op below.
            acc.a         <= '0;
            acc.b         <= '0;
            acc.m         <= '0;
            acc.cin       <= 1'b0;
            acc.issue_vld <= 1'b0;
            done          <= 1'b0;

            if (cap_we && acc.of && (of_count != '1)) begin
                of_count <= of_count + (AW + 1)'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        of_count <= '0;
                        run_len  <= len_clamped;
                        idx      <= '0;
                        if (len_clamped == '0) begin
                            state <= DONE;
                        end else begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    acc.m         <= prog_word[M_LSB +: 4];
                    acc.a         <= prog_word[A_LSB +: 4];
                    acc.b         <= prog_word[B_LSB +: 4];
                    acc.cin       <= prog_word[CIN_LSB];
                    acc.issue_vld <= 1'b1;
                    if (last_issue) begin
                        state <= DRAIN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    // Only the tail (captured on this edge) may still be valid.
                    if (!drain_busy) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered result readback, one cycle behind res_addr.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            res_data <= '0;
        end else begin
            res_data <= res_rdata;
        end
    end

endmodule
